// File: rtl/sisc_ifetch.sv
// Instruction fetch unit: tracks the fetch PC, reads instruction memory and queues words for the core.
// Latency: reset/redirect to first ir_valid is 2 cycles plus the memory ack latency.
// Backpressure: stops requesting while the prefetch FIFO is full; the core pops with ir_take.
//
// Ports:
//   clk, rst_f           clock (rising edge) and asynchronous active-high reset
//   im_req/im_addr       word read request to instruction memory, held until im_ack
//   im_ack/im_data       memory completion and returned instruction word
//   ir/ir_pc/ir_valid    registered FIFO head presented to the core
//   ir_take              core consumes the head (ignored while !ir_valid)
//   br_taken/br_addr     redirect: flush the FIFO and restart fetch at br_addr
//   fetch_cnt/stall_cnt  performance counters, only present with `IFETCH_PERF_EN defined
module sisc_ifetch #(
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_f,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic              im_ack,
  input  logic [31:0]       im_data,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_take,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr
`ifdef IFETCH_PERF_EN
 ,output logic [31:0]       fetch_cnt
 ,output logic [31:0]       stall_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] fpc;

  logic [31:0]       mem_dat [DEPTH];
  logic [ADDR_W-1:0] mem_pc  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  cnt_mid;
  logic [CNT_W-1:0]  cnt_next;
  logic [PTR_W-1:0]  rd_next;
  logic              room;
  logic [ADDR_W-1:0] fpc_inc;
  logic              head_load;
  logic [31:0]       head_dat;
  logic [ADDR_W-1:0] head_pc;

  // A word is kept only when it answers a live REQ and no redirect lands in the same cycle.
  assign push     = (state == REQ) && im_ack && !br_taken;
  assign pop      = ir_valid && ir_take && !br_taken;
  assign cnt_mid  = count - CNT_W'(pop);
  assign cnt_next = cnt_mid + CNT_W'(push);
  assign rd_next  = rd_ptr + PTR_W'(pop);
  assign room     = (cnt_next < FULL_CNT);
  assign fpc_inc  = fpc + ADDR_W'(1);

  // Next head: an older entry if one survives the pop, else the word arriving now,
  // else hold the previous ir/ir_pc.
  always_comb begin
    head_load = 1'b0;
    head_dat  = im_data;
    head_pc   = fpc;
    if (cnt_mid != '0) begin
      head_load = 1'b1;
      head_dat  = mem_dat[rd_next];
      head_pc   = mem_pc[rd_next];
    end else if (push) begin
      head_load = 1'b1;
    end
  end

  // Fetch FSM; im_req/im_addr are registered and stay put while a read is outstanding.
  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      state   <= IDLE;
      im_req  <= 1'b0;
      im_addr <= RESET_PC;
      fpc     <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (br_taken) begin
            // Next cycle issues to the new target with the FIFO already flushed.
            fpc <= br_addr;
          end else if (count < FULL_CNT) begin
            im_req  <= 1'b1;
            im_addr <= fpc;
            state   <= REQ;
          end
        end
        REQ: begin
          if (im_ack) begin
            if (br_taken) begin
              fpc    <= br_addr;
              im_req <= 1'b0;
              state  <= IDLE;
            end else begin
              fpc <= fpc_inc;
              if (room) begin
                im_addr <= fpc_inc;
              end else begin
                im_req <= 1'b0;
                state  <= IDLE;
              end
            end
          end else if (br_taken) begin
            // Read already on the bus: let it finish and throw its data away.
            fpc   <= br_addr;
            state <= DROP;
          end
        end
        DROP: begin
          if (br_taken) begin
            fpc <= br_addr;
          end
          if (im_ack) begin
            im_req <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          im_req <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // FIFO storage holds no control state, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_dat[wr_ptr] <= im_data;
      mem_pc[wr_ptr]  <= fpc;
    end
  end

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else if (br_taken) begin
      rd_ptr   <= wr_ptr;
      count    <= '0;
      ir_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr   <= rd_next;
      count    <= cnt_next;
      ir_valid <= (cnt_next != '0);
      if (head_load) begin
        ir    <= head_dat;
        ir_pc <= head_pc;
      end
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (push) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if ((state == IDLE) && (count == FULL_CNT)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_sisc_ifetch.sv
module tb_sisc_ifetch;

  localparam int AW = 16;
  localparam int DP = 2;

  logic          clk = 1'b0;
  logic          rst_f;
  logic          im_req;
  logic [AW-1:0] im_addr;
  logic          im_ack;
  logic [31:0]   im_data;
  logic [31:0]   ir;
  logic [AW-1:0] ir_pc;
  logic          ir_valid;
  logic          ir_take;
  logic          br_taken;
  logic [AW-1:0] br_addr;
`ifdef IFETCH_PERF_EN
  logic [31:0]   fetch_cnt;
  logic [31:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  sisc_ifetch #(.ADDR_W(AW), .DEPTH(DP), .RESET_PC(16'h0000)) dut (
    .clk      (clk),
    .rst_f    (rst_f),
    .im_req   (im_req),
    .im_addr  (im_addr),
    .im_ack   (im_ack),
    .im_data  (im_data),
    .ir       (ir),
    .ir_pc    (ir_pc),
    .ir_valid (ir_valid),
    .ir_take  (ir_take),
    .br_taken (br_taken),
    .br_addr  (br_addr)
`ifdef IFETCH_PERF_EN
   ,.fetch_cnt(fetch_cnt)
   ,.stall_cnt(stall_cnt)
`endif
  );

  int vec_cnt = 0;
  int miscompares = 0;

  // Memory responder state
  int lat = 1;
  bit rand_lat = 1'b0;
  int age = 0;

  // Reference model: the words the core should see, in order
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [31:0]   dat;
  } ent_t;
  ent_t          q[$];
  logic [AW-1:0] exp_pc;
  bit            dropping;
  bit            pend;
  logic [AW-1:0] pend_addr;
  bit            prev_idle_room;
  bit            br_edge;
  bit            chk_model = 1'b0;
  int            delivered;

  typedef struct {
    bit            rst;
    bit            take;
    bit            req;
    logic [AW-1:0] addr;
    bit            vld;
    logic [AW-1:0] pc;
  } vec_t;
  vec_t tbl [21];

  function automatic vec_t mk(input bit r, input bit t, input bit rq, input logic [AW-1:0] a,
                              input bit v, input logic [AW-1:0] p);
    vec_t e;
    e.rst = r; e.take = t; e.req = rq; e.addr = a; e.vld = v; e.pc = p;
    return e;
  endfunction

  function automatic logic [31:0] mdata(input logic [AW-1:0] a);
    return {~a, a ^ 16'h5A3C};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    exp_pc = 16'h0000;
    dropping = 1'b0;
    pend = 1'b0;
    prev_idle_room = 1'b0;
    br_edge = 1'b0;
    age = 0;
  endtask

  task automatic do_reset();
    rst_f = 1'b1;
    ir_take = 1'b0;
    br_taken = 1'b0;
    br_addr = '0;
    im_ack = 1'b0;
    im_data = '0;
    repeat (2) @(negedge clk);
    rst_f = 1'b0;
    model_clear();
  endtask

  // Memory: ack arrives once the request has been seen for 'lat' cycles.
  task automatic mem_drive();
    im_ack = 1'b0;
    im_data = $urandom;
    if (im_req) begin
      if (age == 0 && rand_lat) lat = $urandom_range(0, 3);
      if (age >= lat) begin
        im_ack = 1'b1;
        im_data = mdata(im_addr);
        age = 0;
      end else begin
        age++;
      end
    end else begin
      age = 0;
    end
  endtask

  // Update the expected stream with what the DUT sees at the coming edge.
  task automatic model_update();
    br_edge = br_taken;
    if (chk_model && im_req && im_ack && !br_taken && !dropping)
      chk("push_addr", im_addr, exp_pc);
    if (br_taken) begin
      q.delete();
      exp_pc = br_addr;
      dropping = im_req && !im_ack;
    end else begin
      if (ir_take && q.size() > 0) begin
        void'(q.pop_front());
        delivered++;
      end
      if (im_req && im_ack) begin
        if (dropping) dropping = 1'b0;
        else begin
          q.push_back('{pc: exp_pc, dat: mdata(exp_pc)});
          exp_pc = exp_pc + 16'd1;
        end
      end
    end
    pend = im_req && !im_ack;
    pend_addr = im_addr;
  endtask

  task automatic model_check();
    chk("ir_valid", ir_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("ir_pc", ir_pc, q[0].pc);
      chk("ir", ir, q[0].dat);
    end
    if (q.size() == DP) chk("full_noreq", im_req, 1'b0);
    if (prev_idle_room && !br_edge) chk("req_issue", im_req, 1'b1);
    if (pend) begin
      chk("req_hold", im_req, 1'b1);
      chk("addr_hold", im_addr, pend_addr);
    end
    prev_idle_room = !im_req && (q.size() < DP);
  endtask

  task automatic tick();
    mem_drive();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit            found;
    logic [AW-1:0] reqs[$];
    logic [AW-1:0] pcs[$];
    int            take_pct;

    rst_f = 1'b1;
    ir_take = 1'b0;
    br_taken = 1'b0;
    br_addr = '0;
    im_ack = 1'b0;
    im_data = '0;
    delivered = 0;
    model_clear();

    // Streaming with ir_take=1, then stalling with ir_take=0 (ack one cycle after req).
    tbl[0]  = mk(1, 1, 0, 16'h0, 0, 16'h0);
    tbl[1]  = mk(0, 1, 1, 16'h0, 0, 16'h0);
    tbl[2]  = mk(0, 1, 1, 16'h0, 0, 16'h0);
    tbl[3]  = mk(0, 1, 1, 16'h1, 1, 16'h0);
    tbl[4]  = mk(0, 1, 1, 16'h1, 0, 16'h0);
    tbl[5]  = mk(0, 1, 1, 16'h2, 1, 16'h1);
    tbl[6]  = mk(0, 1, 1, 16'h2, 0, 16'h0);
    tbl[7]  = mk(0, 1, 1, 16'h3, 1, 16'h2);
    tbl[8]  = mk(0, 1, 1, 16'h3, 0, 16'h0);
    tbl[9]  = mk(0, 1, 1, 16'h4, 1, 16'h3);
    tbl[10] = mk(1, 0, 0, 16'h0, 0, 16'h0);
    tbl[11] = mk(0, 0, 1, 16'h0, 0, 16'h0);
    tbl[12] = mk(0, 0, 1, 16'h0, 0, 16'h0);
    tbl[13] = mk(0, 0, 1, 16'h1, 1, 16'h0);
    tbl[14] = mk(0, 0, 1, 16'h1, 1, 16'h0);
    tbl[15] = mk(0, 0, 0, 16'h0, 1, 16'h0);
    tbl[16] = mk(0, 1, 0, 16'h0, 1, 16'h0);
    tbl[17] = mk(0, 0, 0, 16'h0, 1, 16'h1);
    tbl[18] = mk(0, 0, 1, 16'h2, 1, 16'h1);
    tbl[19] = mk(0, 0, 1, 16'h2, 1, 16'h1);
    tbl[20] = mk(0, 0, 0, 16'h0, 1, 16'h1);

    lat = 1;
    for (int i = 0; i < 21; i++) begin
      if (tbl[i].rst) begin
        do_reset();
        chk("rst_im_addr", im_addr, 16'h0000);
        chk("rst_ir", ir, 32'h0);
        chk("rst_ir_pc", ir_pc, 16'h0000);
      end
      chk($sformatf("tbl%0d_req", i), im_req, tbl[i].req);
      if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), im_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_vld", i), ir_valid, tbl[i].vld);
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_pc", i), ir_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_ir", i), ir, mdata(tbl[i].pc));
      end
      ir_take = tbl[i].take;
      tick();
    end

    // Redirect while the read of PC 5 is outstanding; that read acks 3 cycles later.
    do_reset();
    lat = 1;
    ir_take = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (im_req && im_addr == 16'h0005 && age == 0) found = 1'b1;
      else tick();
    end
    chk("t3_reach", found, 1'b1);
    lat = 3;
    br_taken = 1'b1;
    br_addr = 16'h0040;
    tick();
    br_taken = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("t3_drop_req", im_req, 1'b1);
      chk("t3_drop_addr", im_addr, 16'h0005);
      chk("t3_drop_vld", ir_valid, 1'b0);
      tick();
    end
    lat = 1;
    chk("t3_idle_req", im_req, 1'b0);
    chk("t3_idle_vld", ir_valid, 1'b0);
    tick();
    chk("t3_new_req", im_req, 1'b1);
    chk("t3_new_addr", im_addr, 16'h0040);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (ir_valid) found = 1'b1;
      else tick();
    end
    chk("t3_first_vld", found, 1'b1);
    chk("t3_first_pc", ir_pc, 16'h0040);
    chk("t3_first_ir", ir, mdata(16'h0040));

    // Redirect in the same cycle as an ack, with PC 0 already queued.
    do_reset();
    lat = 1;
    ir_take = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (im_req && im_addr == 16'h0001 && age >= lat) found = 1'b1;
      else tick();
    end
    chk("t4_reach", found, 1'b1);
    br_taken = 1'b1;
    br_addr = 16'h0100;
    tick();
    br_taken = 1'b0;
    chk("t4_flush_vld", ir_valid, 1'b0);
    chk("t4_idle_req", im_req, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (ir_valid) found = 1'b1;
      else tick();
    end
    chk("t4_first_vld", found, 1'b1);
    chk("t4_first_pc", ir_pc, 16'h0100);
    chk("t4_first_ir", ir, mdata(16'h0100));

    // Fetch PC wraps from all-ones to zero (zero-wait memory).
    do_reset();
    lat = 0;
    ir_take = 1'b1;
    br_taken = 1'b1;
    br_addr = 16'hFFFF;
    tick();
    br_taken = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (im_req) reqs.push_back(im_addr);
      if (ir_valid) pcs.push_back(ir_pc);
      tick();
    end
    chk("t5_nreq", reqs.size() >= 2, 1'b1);
    chk("t5_npc", pcs.size() >= 2, 1'b1);
    if (reqs.size() >= 2) begin
      chk("t5_req0", reqs[0], 16'hFFFF);
      chk("t5_req1", reqs[1], 16'h0000);
    end
    if (pcs.size() >= 2) begin
      chk("t5_pc0", pcs[0], 16'hFFFF);
      chk("t5_pc1", pcs[1], 16'h0000);
    end

    // Asynchronous reset mid-request, away from any clock edge.
    do_reset();
    lat = 1;
    ir_take = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (im_req && ir_valid) found = 1'b1;
      else tick();
    end
    chk("t6_reach", found, 1'b1);
`ifdef IFETCH_PERF_EN
    chk("t6_fetch_cnt_pre", fetch_cnt, 32'd1);
`endif
    #3;
    rst_f = 1'b1;
    im_ack = 1'b0;
    #1;
    chk("t6_rst_req", im_req, 1'b0);
    chk("t6_rst_vld", ir_valid, 1'b0);
    chk("t6_rst_addr", im_addr, 16'h0000);
`ifdef IFETCH_PERF_EN
    chk("t6_fetch_cnt", fetch_cnt, 32'd0);
    chk("t6_stall_cnt", stall_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_f = 1'b0;
    model_clear();
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (ir_valid) found = 1'b1;
      else tick();
    end
    chk("t6_restart_vld", found, 1'b1);
    chk("t6_restart_pc", ir_pc, 16'h0000);

    // Randomized traffic against the stream model.
    do_reset();
    chk_model = 1'b1;
    rand_lat = 1'b1;
    delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      model_check();
      take_pct = ((i / 500) % 2) ? 30 : 85;
      ir_take = ($urandom_range(0, 99) < take_pct);
      br_taken = ($urandom_range(0, 19) == 0);
      br_addr = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      tick();
    end
    chk_model = 1'b0;
    rand_lat = 1'b0;
    chk("rand_progress", delivered > 100, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
